// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// Build option CTRL_OPIMM_EN enables decoding of the OP-IMM opcode group.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Sequencing class of a decoded instruction.
  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_BNE   = 3'd4
  } cls_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation for the funct7=0000000 forms of OP / OP-IMM.
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      F3_ADD_SUB: code = ALU_ADD;
      F3_SLL:     code = ALU_SLL;
      F3_SLT:     code = ALU_SLT;
      F3_SLTU:    code = ALU_SLTU;
      F3_XOR:     code = ALU_XOR;
      F3_SRL_SRA: code = ALU_SRL;
      F3_OR:      code = ALU_OR;
      F3_AND:     code = ALU_AND;
      default:    code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: IR -> register fields, immediate, ALU control, class.
// With CTRL_OPIMM_EN defined, OP-IMM instructions take the register-register path with alu_src=1.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output cls_t        cls,
  output logic        illegal
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;

  assign opcode_s = ir[6:0];
  assign funct3_s = ir[14:12];
  assign funct7_s = ir[31:25];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rd       = ir[11:7];
  assign imm_i_s  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b_s  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // Opcode/funct decode; anything not recognised raises illegal.
  always_comb begin
    imm      = 32'h0000_0000;
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    cls      = CLS_ALU;
    illegal  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == F7_BASE) begin
          alu_ctrl = alu_base(funct3_s);
        end else if ((funct7_s == F7_ALT) && (funct3_s == F3_ADD_SUB)) begin
          alu_ctrl = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == F3_SRL_SRA)) begin
          alu_ctrl = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
`ifdef CTRL_OPIMM_EN
      OPC_OP_IMM: begin
        imm     = imm_i_s;
        alu_src = 1'b1;
        case (funct3_s)
          F3_SLL: begin
            if (funct7_s == F7_BASE) alu_ctrl = ALU_SLL;
            else                     illegal  = 1'b1;
          end
          F3_SRL_SRA: begin
            if (funct7_s == F7_BASE)     alu_ctrl = ALU_SRL;
            else if (funct7_s == F7_ALT) alu_ctrl = ALU_SRA;
            else                         illegal  = 1'b1;
          end
          default: alu_ctrl = alu_base(funct3_s);
        endcase
      end
`else
      OPC_OP_IMM: illegal = 1'b1;
`endif
      OPC_LOAD: begin
        imm     = imm_i_s;
        alu_src = 1'b1;
        if (funct3_s == F3_WORD) cls     = CLS_LOAD;
        else                     illegal = 1'b1;
      end
      OPC_STORE: begin
        imm     = imm_s_s;
        alu_src = 1'b1;
        if (funct3_s == F3_WORD) cls     = CLS_STORE;
        else                     illegal = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = imm_b_s;
        alu_ctrl = ALU_SUB;
        if (funct3_s == F3_BEQ)      cls     = CLS_BEQ;
        else if (funct3_s == F3_BNE) cls     = CLS_BNE;
        else                         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch handshake, PC, instruction sequencing, memory wait.
// OP-IMM support is selected by the CTRL_OPIMM_EN macro inside ctrl_decode.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic        alu_src,
  output logic [3:0]  alu_ctrl,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  input  logic        dmem_ready,
  input  logic        zero_flag,
  output logic        illegal
);

  state_t      state_r;
  cls_t        cls_r;
  logic [31:0] pc_r;
  logic [31:0] ir_r;

  logic [4:0]  dec_rs1_s;
  logic [4:0]  dec_rs2_s;
  logic [4:0]  dec_rd_s;
  logic [31:0] dec_imm_s;
  logic [3:0]  dec_alu_ctrl_s;
  logic        dec_alu_src_s;
  cls_t        dec_cls_s;
  logic        dec_illegal_s;
  logic        taken_s;
  logic [31:0] pc_seq_s;
  logic [31:0] pc_target_s;

  ctrl_decode u_decode (
    .ir       (ir_r),
    .rs1      (dec_rs1_s),
    .rs2      (dec_rs2_s),
    .rd       (dec_rd_s),
    .imm      (dec_imm_s),
    .alu_ctrl (dec_alu_ctrl_s),
    .alu_src  (dec_alu_src_s),
    .cls      (dec_cls_s),
    .illegal  (dec_illegal_s)
  );

  assign if_addr     = pc_r;
  assign taken_s     = (cls_r == CLS_BEQ) ? zero_flag : ~zero_flag;
  assign pc_seq_s    = pc_r + 32'd4;
  assign pc_target_s = pc_r + imm;

  // Instruction sequencer with registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_FETCH;
      cls_r      <= CLS_ALU;
      pc_r       <= RESET_PC;
      ir_r       <= 32'h0000_0000;
      if_req     <= 1'b0;
      rs1_addr   <= 5'd0;
      rs2_addr   <= 5'd0;
      rd_addr    <= 5'd0;
      imm        <= 32'h0000_0000;
      alu_src    <= 1'b0;
      alu_ctrl   <= ALU_ADD;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // An ack only counts while our request is actually outstanding.
          if (if_req && if_ack) begin
            ir_r    <= if_rdata;
            if_req  <= 1'b0;
            state_r <= ST_DECODE;
          end else begin
            if_req  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_illegal_s) begin
            illegal <= 1'b1;
            state_r <= ST_HALT;
          end else begin
            rs1_addr <= dec_rs1_s;
            rs2_addr <= dec_rs2_s;
            rd_addr  <= dec_rd_s;
            imm      <= dec_imm_s;
            alu_ctrl <= dec_alu_ctrl_s;
            alu_src  <= dec_alu_src_s;
            cls_r    <= dec_cls_s;
            state_r  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_r)
            CLS_ALU: begin
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b0;
              state_r    <= ST_WB;
            end
            CLS_LOAD: begin
              mem_read <= 1'b1;
              state_r  <= ST_MEM;
            end
            CLS_STORE: begin
              mem_write <= 1'b1;
              state_r   <= ST_MEM;
            end
            CLS_BEQ, CLS_BNE: begin
              pc_r    <= taken_s ? pc_target_s : pc_seq_s;
              if_req  <= 1'b1;
              state_r <= ST_FETCH;
            end
            default: begin
              illegal <= 1'b1;
              state_r <= ST_HALT;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (cls_r == CLS_LOAD) begin
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b1;
              state_r    <= ST_WB;
            end else begin
              pc_r    <= pc_seq_s;
              if_req  <= 1'b1;
              state_r <= ST_FETCH;
            end
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB: begin
          reg_write  <= 1'b0;
          mem_to_reg <= 1'b0;
          pc_r       <= pc_seq_s;
          if_req     <= 1'b1;
          state_r    <= ST_FETCH;
        end
        ST_HALT: begin
          if_req     <= 1'b0;
          reg_write  <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_to_reg <= 1'b0;
        end
        default: begin
          if_req     <= 1'b0;
          reg_write  <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_to_reg <= 1'b0;
          state_r    <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed vector table, corner-case sequences, random instructions.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack = 1'b0;
  logic [31:0] if_rdata = 32'h0;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic        dmem_ready = 1'b0;
  logic        zero_flag = 1'b0;
  logic        illegal;

  always #5 clk = ~clk;

  ctrl_fsm #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .dmem_ready(dmem_ready), .zero_flag(zero_flag), .illegal(illegal)
  );

`ifdef CTRL_OPIMM_EN
  localparam int NKIND = 6;
`else
  localparam int NKIND = 5;
`endif

  // kind: 0 register/ALU path, 1 LW, 2 SW, 3 BEQ, 4 BNE
  typedef struct {
    logic [31:0] instr;
    logic        zf;
    int          kind;
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic        ci;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        crs2;
    logic        crd;
    int          ackw;
    int          rdyw;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_m = 32'h0;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (pc 0x%08h)", name, act, exp, pc_m);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] instr, input logic zf, input int kind,
                               input logic [3:0] alu, input logic src, input logic [31:0] iv,
                               input logic ci, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic crs2, input logic crd,
                               input int ackw, input int rdyw);
    vec_t v;
    v.instr = instr; v.zf = zf; v.kind = kind; v.alu = alu; v.src = src; v.imm = iv;
    v.ci = ci; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.crs2 = crs2; v.crd = crd;
    v.ackw = ackw; v.rdyw = rdyw;
    return v;
  endfunction

  // Register-register mnemonic table, indexed by ALU code.
  function automatic void r_fields(input int idx, output logic [6:0] f7, output logic [2:0] f3);
    case (idx)
      0: begin f7 = 7'h00; f3 = 3'd0; end
      1: begin f7 = 7'h20; f3 = 3'd0; end
      2: begin f7 = 7'h00; f3 = 3'd7; end
      3: begin f7 = 7'h00; f3 = 3'd6; end
      4: begin f7 = 7'h00; f3 = 3'd4; end
      5: begin f7 = 7'h00; f3 = 3'd1; end
      6: begin f7 = 7'h00; f3 = 3'd5; end
      7: begin f7 = 7'h20; f3 = 3'd5; end
      8: begin f7 = 7'h00; f3 = 3'd2; end
      default: begin f7 = 7'h00; f3 = 3'd3; end
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    int          k, iv, idx;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] e;
    logic [11:0] f;
    logic [12:0] b;
    logic [3:0]  alu;
    logic        zf;
    k = $urandom_range(0, NKIND - 1);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    zf = 1'($urandom);
    iv = int'($urandom_range(0, 4095)) - 2048;
    e = iv; f = e[11:0];
    case (k)
      0: begin
        idx = $urandom_range(0, 9);
        r_fields(idx, f7, f3);
        v = mkv({f7, rs2, rs1, f3, rd, 7'b0110011}, zf, 0, 4'(idx), 1'b0, 32'h0, 1'b0,
                rd, rs1, rs2, 1'b1, 1'b1, 0, 0);
      end
      1: v = mkv({f, rs1, 3'b010, rd, 7'b0000011}, zf, 1, 4'd0, 1'b1, e, 1'b1,
                 rd, rs1, rs2, 1'b0, 1'b1, 0, 0);
      2: v = mkv({f[11:5], rs2, rs1, 3'b010, f[4:0], 7'b0100011}, zf, 2, 4'd0, 1'b1, e, 1'b1,
                 rd, rs1, rs2, 1'b1, 1'b0, 0, 0);
      3, 4: begin
        e = e * 32'd2; b = e[12:0];
        v = mkv({b[12], b[10:5], rs2, rs1, (k == 4) ? 3'b001 : 3'b000, b[4:1], b[11], 7'b1100011},
                zf, k, 4'd1, 1'b0, e, 1'b1, rd, rs1, rs2, 1'b1, 1'b0, 0, 0);
      end
      default: begin
        idx = $urandom_range(0, 8);
        sh = 5'($urandom);
        case (idx)
          0: begin f3 = 3'd0; alu = 4'd0; end
          1: begin f3 = 3'd2; alu = 4'd8; end
          2: begin f3 = 3'd3; alu = 4'd9; end
          3: begin f3 = 3'd4; alu = 4'd4; end
          4: begin f3 = 3'd6; alu = 4'd3; end
          5: begin f3 = 3'd7; alu = 4'd2; end
          6: begin f3 = 3'd1; alu = 4'd5; f = {7'h00, sh}; end
          7: begin f3 = 3'd5; alu = 4'd6; f = {7'h00, sh}; end
          default: begin f3 = 3'd5; alu = 4'd7; f = {7'h20, sh}; end
        endcase
        if (idx >= 6) e = {20'h0, f};
        v = mkv({f, rs1, f3, rd, 7'b0010011}, zf, 0, alu, 1'b1, e, 1'b1,
                rd, rs1, rs2, 1'b0, 1'b1, 0, 0);
      end
    endcase
    v.ackw = $urandom_range(0, 2);
    v.rdyw = $urandom_range(0, 3);
    return v;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!if_req && n < 20) begin @(negedge clk); n++; end
    chk("fetch_req", 32'(if_req), 32'd1);
    chk("fetch_addr", if_addr, pc_m);
  endtask

  // Runs one instruction through fetch..next fetch and compares against the expected behaviour.
  task automatic do_instr(input vec_t v);
    int   cyc, rw, mr, mw, m2r, both, memc, exp_cyc;
    logic taken;
    wait_req();
    for (int i = 0; i < v.ackw; i++) @(negedge clk);
    if (v.ackw > 0) begin
      chk("fetch_hold_req", 32'(if_req), 32'd1);
      chk("fetch_hold_addr", if_addr, pc_m);
    end
    if_ack = 1'b1; if_rdata = v.instr; zero_flag = v.zf;
    @(negedge clk);
    if_ack = 1'b0; if_rdata = $urandom;
    cyc = 1 + v.ackw; rw = 0; mr = 0; mw = 0; m2r = 0; both = 0; memc = 0;
    while (!if_req && cyc < 60) begin
      rw  += int'(reg_write);
      mr  += int'(mem_read);
      mw  += int'(mem_write);
      m2r += int'(reg_write && mem_to_reg);
      if (int'(reg_write) + int'(mem_read) + int'(mem_write) > 1) both++;
      if (mem_read || mem_write) begin
        memc++;
        dmem_ready = (memc > v.rdyw);
      end else begin
        dmem_ready = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    dmem_ready = 1'b0;
    chk("instr_done", 32'(cyc < 60), 32'd1);
    case (v.kind)
      0: exp_cyc = 4;
      1: exp_cyc = 5 + v.rdyw;
      2: exp_cyc = 4 + v.rdyw;
      default: exp_cyc = 3;
    endcase
    chk("latency", 32'(cyc), 32'(exp_cyc + v.ackw));
    chk("reg_write_cycles", 32'(rw), (v.kind <= 1) ? 32'd1 : 32'd0);
    chk("mem_read_cycles", 32'(mr), (v.kind == 1) ? 32'(v.rdyw + 1) : 32'd0);
    chk("mem_write_cycles", 32'(mw), (v.kind == 2) ? 32'(v.rdyw + 1) : 32'd0);
    chk("mem_to_reg_cycles", 32'(m2r), (v.kind == 1) ? 32'd1 : 32'd0);
    chk("strobe_overlap", 32'(both), 32'd0);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(v.alu));
    chk("alu_src", 32'(alu_src), 32'(v.src));
    chk("rs1_addr", 32'(rs1_addr), 32'(v.rs1));
    if (v.ci) chk("imm", imm, v.imm);
    if (v.crs2) chk("rs2_addr", 32'(rs2_addr), 32'(v.rs2));
    if (v.crd) chk("rd_addr", 32'(rd_addr), 32'(v.rd));
    taken = (v.kind == 3) ? v.zf : (v.kind == 4) ? !v.zf : 1'b0;
    pc_m = taken ? pc_m + v.imm : pc_m + 32'd4;
    chk("next_pc", if_addr, pc_m);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_pc", if_addr, 32'h0000_0000);
    chk("reset_req", 32'(if_req), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pc_m = 32'h0;
  endtask

  // Fetches an instruction expected to be illegal, checks the halt is silent and sticky, then resets.
  task automatic check_illegal(input logic [31:0] instr);
    int bad = 0;
    wait_req();
    if_ack = 1'b1; if_rdata = instr;
    @(negedge clk);
    if_ack = 1'b0;
    @(negedge clk);
    chk("illegal_set", 32'(illegal), 32'd1);
    repeat (8) begin
      dmem_ready = 1'($urandom); if_ack = 1'($urandom);
      @(negedge clk);
      if (if_req || reg_write || mem_read || mem_write) bad++;
    end
    if_ack = 1'b0; dmem_ready = 1'b0;
    chk("halt_quiet", 32'(bad), 32'd0);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    reset_dut();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t lw_v;
    int   n;
    vecs.push_back(mkv(32'h002081B3, 1'b0, 0, 4'd0, 1'b0, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'h0080A283, 1'b0, 1, 4'd0, 1'b1, 32'h8, 1'b1, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1, 0, 3));
    vecs.push_back(mkv(32'h0020A223, 1'b0, 2, 4'd0, 1'b1, 32'h4, 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1, 2));
    vecs.push_back(mkv(32'h40628233, 1'b1, 0, 4'd1, 1'b0, 32'h0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 2, 0));
    vecs.push_back(mkv(32'hFE208CE3, 1'b1, 3, 4'd1, 1'b0, 32'hFFFF_FFF8, 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mkv(32'h009473B3, 1'b0, 0, 4'd2, 1'b0, 32'h0, 1'b0, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'h00C5E533, 1'b0, 0, 4'd3, 1'b0, 32'h0, 1'b0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'hFE208CE3, 1'b0, 3, 4'd1, 1'b0, 32'hFFFF_FFF8, 1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mkv(32'h403150B3, 1'b0, 0, 4'd7, 1'b0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'h01DF3FB3, 1'b1, 0, 4'd9, 1'b0, 32'h0, 1'b0, 5'd31, 5'd30, 5'd29, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'hFFF12303, 1'b0, 1, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd2, 5'd0, 1'b0, 1'b1, 0, 0));
    vecs.push_back(mkv(32'h00419863, 1'b0, 4, 4'd1, 1'b0, 32'h10, 1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mkv(32'h00208033, 1'b0, 0, 4'd0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mkv(32'h00419863, 1'b1, 4, 4'd1, 1'b0, 32'h10, 1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 0, 0));

    repeat (3) @(negedge clk);
    chk("rst_if_req", 32'(if_req), 32'd0);
    chk("rst_if_addr", if_addr, 32'h0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_strobes", 32'({reg_write, mem_read, mem_write, mem_to_reg, alu_src, illegal}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_rise_after_release", 32'(if_req), 32'd1);

    foreach (vecs[i]) do_instr(vecs[i]);

    // Reset while a load is waiting on memory; late ack/ready must be ignored.
    lw_v = vecs[1];
    wait_req();
    if_ack = 1'b1; if_rdata = lw_v.instr;
    @(negedge clk);
    if_ack = 1'b0;
    n = 0;
    while (!mem_read && n < 10) begin @(negedge clk); n++; end
    chk("mem_read_seen", 32'(mem_read), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_mem_read_drop", 32'(mem_read), 32'd0);
    chk("async_pc_reset", if_addr, 32'h0);
    dmem_ready = 1'b1; if_ack = 1'b1; if_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    pc_m = 32'h0;
    @(negedge clk);
    if_ack = 1'b0; dmem_ready = 1'b0;
    chk("stale_ack_ignored", 32'(if_req), 32'd1);
    do_instr(vecs[0]);

    check_illegal(32'hFFFF_FFFF);

`ifdef CTRL_OPIMM_EN
    do_instr(mkv(32'h00500093, 1'b0, 0, 4'd0, 1'b1, 32'h5, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 0, 0));
    check_illegal({7'h20, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0010011});
`else
    check_illegal(32'h00500093);
`endif

    for (int i = 0; i < 40; i++) do_instr(rand_vec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle RV32I control unit that drives the datapath's control interface. It fetches instruction words over a req/ack handshake, decodes them into register addresses, immediate, ALU control and memory/write-back strobes, sequences each instruction through fixed states, and consumes zero_flag to resolve branches. It owns the PC and the data-memory wait handshake.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
if_req  out  1  instruction fetch request.
if_addr  out  32  fetch address (current PC).
if_ack  in  1  fetch data valid this cycle.
if_rdata  in  32  instruction word.
rs1_addr  out  5  datapath source 1.
rs2_addr  out  5  datapath source 2.
rd_addr  out  5  datapath destination.
imm  out  32  sign-extended immediate.
alu_src  out  1  1 selects imm as ALU op_b.
alu_ctrl  out  4  ALU operation.
reg_write  out  1  register write strobe.
mem_read  out  1  data-memory read.
mem_write  out  1  data-memory write.
mem_to_reg  out  1  write-back selects memory data.
dmem_ready  in  1  data-memory access complete.
zero_flag  in  1  ALU zero from datapath.
illegal  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset (rst low, async): state FETCH, PC=RESET_PC, instruction register 0, every output 0 (imm=0, alu_ctrl=ADD). Any in-flight fetch or memory access is abandoned; ack/ready arriving after reset is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: if_req=1, if_addr=PC held stable until if_ack; on ack latch if_rdata into IR, drop if_req the next cycle -> DECODE. if_req rises one cycle after reset release.
- DECODE (1 cycle): register outputs rs1/rs2/rd/imm/alu_ctrl/alu_src from IR; they stay stable through the end of the instruction. Unsupported opcode/funct -> set illegal, -> HALT.
- EXEC (1 cycle): datapath computes. R-type -> WB. LOAD/STORE (alu_ctrl=ADD, alu_src=1) -> MEM. BRANCH (alu_ctrl=SUB, alu_src=0): BEQ taken if zero_flag=1, BNE if 0; PC<=PC+imm if taken, else PC+4 -> FETCH.
- MEM: mem_read (LW) or mem_write (SW) held high until the cycle dmem_ready=1 (inclusive). LW -> WB, SW -> PC+4, FETCH. dmem_ready already high on entry completes in 1 cycle.
- WB (1 cycle): reg_write=1; mem_to_reg=1 for LW else 0; PC<=PC+4 -> FETCH. rd=x0 still strobes (the register file ignores it).
- HALT: terminal; all strobes 0; exit only by reset.
- Latency (zero-wait ack/ready): R-type 4 cycles, LW 5, SW 4, branch 3, each plus fetch wait cycles.
- imm: I-type [31:20], S-type {[31:25],[11:7]}, B-type {[31],[7],[30:25],[11:8],0}, all sign-extended to 32. PC arithmetic wraps mod 2^32; the misaligned branch target is not checked.
- alu_ctrl codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- reg_write, mem_read and mem_write are never high simultaneously.

Optional Feature:
CTRL_OPIMM_EN. Defined: opcode 0010011 (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) is decoded with alu_src=1 and follows the R-type path; shift immediates with bad funct7 are illegal. Undefined: opcode 0010011 is illegal -> HALT.

Decomposition:
- Package ctrl_pkg: state enum, alu_ctrl constants, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH), funct3/funct7 constants.
- One sub-module ctrl_decode: combinational IR -> {rs1, rs2, rd, imm, alu_ctrl, alu_src, class, illegal}. The FSM, PC and handshakes stay in ctrl_fsm.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with immediate ack -> if_addr=0, alu_ctrl=0, reg_write pulses exactly 1 cycle in cycle 4, next if_addr=4.
- LW x5,8(x1) (0x0080A283), dmem_ready delayed 3 cycles -> mem_read high 4 cycles, imm=8, alu_src=1, then WB with mem_to_reg=1, reg_write=1.
- BEQ x1,x2,-8 at PC=0x10 (0xFE208CE3), zero_flag=1 -> alu_ctrl=1, next if_addr=0x08; repeat with zero_flag=0 -> next if_addr=0x14.
- SW x2,4(x1) (0x0020A223) -> mem_write high until dmem_ready, reg_write never asserted, next if_addr=PC+4.
- Instruction 0xFFFFFFFF -> illegal=1, HALT, no further if_req; rst low -> illegal=0, if_addr=RESET_PC.
- rst asserted while in MEM with mem_read=1 -> mem_read drops asynchronously; ADDI x1,x0,5 (0x00500093) is legal with CTRL_OPIMM_EN (imm=5, alu_src=1), illegal without.
